// File: rtl/majority_pkg.sv
// Shared types for the majority-vote path: voter count, ballot vector and
// the collector FSM state encoding.
package majority_pkg;

  localparam int NUM_VOTERS = 3;

  typedef logic [NUM_VOTERS-1:0] ballot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collect_state_t;

endpackage

// File: rtl/round_timer.sv
// Round timer for the vote collector. Counts enabled cycles since the last
// clear and flags the final permitted cycle of a round.
module round_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins; otherwise advance while the round is running.
  // A round can reach at most TIMEOUT, which fits CNT_W, so no wrap occurs.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/vote_collector.sv
// Vote collector: runs one voting round at a time, latching at most one
// ballot per voter, and presents the complete ballot vector in DONE.
//
// Build option: define VOTE_CHANGE_EN to let voters re-cast during a round
// (last vote wins). Rounds then always run the full TIMEOUT cycles.
//
//   state   | meaning
//   IDLE    | after reset, outputs all zero, waiting for start
//   COLLECT | accepting ballots, timer running
//   DONE    | ballots frozen and presented on votes, waiting for start
module vote_collector
  import majority_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_VOTERS-1:0] vote_en,
  input  logic [NUM_VOTERS-1:0] vote_val,
  output logic [NUM_VOTERS-1:0] votes,
  output logic [NUM_VOTERS-1:0] voted,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out
);

  collect_state_t state_q;
  collect_state_t state_d;
  ballot_t        ballot_q;
  ballot_t        ballot_d;
  ballot_t        voted_q;
  ballot_t        voted_d;
  logic           timed_out_q;
  logic           timed_out_d;

  ballot_t        accept;
  ballot_t        voted_next;
  logic           all_voted;
  logic           start_ok;
  logic           in_collect;
  logic           expired;

  assign in_collect = (state_q == COLLECT);
  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));

  // Which voters are latched this cycle, and whether that completes the round.
`ifdef VOTE_CHANGE_EN
  assign accept    = in_collect ? vote_en : '0;
  assign all_voted = 1'b0;
`else
  assign accept    = in_collect ? (vote_en & ~voted_q) : '0;
  assign all_voted = (voted_next == '1);
`endif
  assign voted_next = voted_q | accept;

  round_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_round_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .enable  (in_collect),
    .expired (expired)
  );

  // Round sequencing and ballot latching.
  always_comb begin
    state_d     = state_q;
    ballot_d    = ballot_q;
    voted_d     = voted_q;
    timed_out_d = timed_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d     = COLLECT;
          ballot_d    = '0;
          voted_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      COLLECT: begin
        ballot_d = (ballot_q & ~accept) | (vote_val & accept);
        voted_d  = voted_next;
        if (all_voted) begin
          state_d     = DONE;
          timed_out_d = 1'b0;
        end else if (expired) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and ballot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ballot_q    <= '0;
      voted_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ballot_q    <= ballot_d;
      voted_q     <= voted_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Outputs decode straight from registers so reset clears them at once.
  assign busy      = in_collect;
  assign done      = (state_q == DONE);
  assign votes     = done ? ballot_q : '0;
  assign voted     = voted_q;
  assign timed_out = done && timed_out_q;

endmodule
